// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multicycle MIPS controller.
package mips_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: maps aluop and funct to the ALU operation code.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl
);
  logic [2:0] fn_ctrl;
  always_comb begin
    fn_ctrl = ALU_ADD;
    case (funct)
      FN_SUB:  fn_ctrl = ALU_SUB;
      FN_AND:  fn_ctrl = ALU_AND;
      FN_OR:   fn_ctrl = ALU_OR;
      FN_SLT:  fn_ctrl = ALU_SLT;
      default: fn_ctrl = ALU_ADD;
    endcase
  end
  assign alu_ctrl = aluop == ALUOP_SUB ? ALU_SUB : aluop == ALUOP_FUNCT ? fn_ctrl : ALU_ADD;
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM for a multicycle MIPS datapath with a
// handshaked memory; pcen is the only output that also looks at zero.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alu_ctrl,
  output logic       pcen,
  output logic       illegal_op,
  output logic [3:0] state
);
  state_t state_q, state_d;
  aluop_t aluop;
  logic pcwrite, branch, legal;
  logic [2:0] dec_ctrl;
  always_ff @(posedge clk) state_q <= rst ? S_FETCH : state_d;
  assign legal = opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                          opcode == OP_RTYPE ? S_EXEC :
                          opcode == OP_BEQ ? S_BRANCH :
                          opcode == OP_ADDI ? S_ADDIEX :
                          opcode == OP_J ? S_JUMP : S_FETCH;
      S_MEMADR: state_d = opcode == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end
  always_comb begin
    iord = 1'b0;
    irwrite = 1'b0;
    memwrite = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    aluop = ALUOP_ADD;
    pcwrite = 1'b0;
    branch = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illegal_op = !legal;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord = 1'b1;
        memwrite = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop = ALUOP_SUB;
        pcsrc = 2'b01;
        branch = 1'b1;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end
  mips_alu_decoder u_dec (
    .aluop(aluop),
    .funct(funct),
    .alu_ctrl(dec_ctrl)
  );
  // Encodings 12-15 are not states at all, so even the ALU code is forced to 0.
  assign alu_ctrl = state_q <= S_JUMP ? dec_ctrl : 3'b000;
  assign pcen = pcwrite | (branch & zero);
  assign state = state_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: random instruction streams checked cycle by cycle
// against a scoreboard filled from an instruction-level model of the controller.
module tb_mips_multicycle_ctrl;
  typedef struct packed {
    logic [3:0] st;
    logic iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alu;
    logic pcen, ill;
  } vec_t;
  typedef struct packed {
    logic chk_alu;
    vec_t v;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alu_ctrl;
  logic [3:0] state;
  exp_t sb[$];
  int errors = 0, checks = 0, ncyc = 0;
  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alu_ctrl(alu_ctrl), .pcen(pcen),
    .illegal_op(illegal_op), .state(state)
  );
  always #5 clk = ~clk;
  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction
  function automatic logic [2:0] funct_op(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction
  // What the controller must show while in step s of an instruction.
  function automatic exp_t expect_of(input int s, input bit mr, input bit z,
                                     input logic [5:0] fn, input logic [5:0] op);
    exp_t e;
    e = '0;
    e.v.st = 4'(s);
    e.chk_alu = 1'b1;
    e.v.alu = 3'b010;
    case (s)
      0: begin e.v.alusrcb = 2'b01; e.v.irwrite = mr; e.v.pcen = mr; end
      1: begin e.v.alusrcb = 2'b11; e.v.ill = !is_legal(op); end
      2, 9: begin e.v.alusrca = 1'b1; e.v.alusrcb = 2'b10; end
      3: begin e.v.iord = 1'b1; e.chk_alu = 1'b0; end
      4: begin e.v.memtoreg = 1'b1; e.v.regwrite = 1'b1; e.chk_alu = 1'b0; end
      5: begin e.v.iord = 1'b1; e.v.memwrite = 1'b1; e.chk_alu = 1'b0; end
      6: begin e.v.alusrca = 1'b1; e.v.alu = funct_op(fn); end
      7: begin e.v.regdst = 1'b1; e.v.regwrite = 1'b1; e.chk_alu = 1'b0; end
      8: begin e.v.alusrca = 1'b1; e.v.alu = 3'b110; e.v.pcsrc = 2'b01; e.v.pcen = z; end
      10: begin e.v.regwrite = 1'b1; e.chk_alu = 1'b0; end
      11: begin e.v.pcsrc = 2'b10; e.v.pcen = 1'b1; e.chk_alu = 1'b0; end
      default: e.chk_alu = 1'b0;
    endcase
    return e;
  endfunction
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      vec_t a;
      e = sb.pop_front();
      a = {state, iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, alu_ctrl, pcen, illegal_op};
      if (!e.chk_alu) a.alu = e.v.alu;
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL cycle %0d: outputs got %h want %h (state got %0d want %0d)",
                 ncyc, a, e.v, state, e.v.st);
      end
    end
  end
  task automatic drive(input int s, input bit mr, input bit r);
    mem_ready = mr;
    rst = r;
    sb.push_back(expect_of(s, mr, zero, funct, opcode));
    @(posedge clk);
    #1;
    rst = 1'b0;
    ncyc++;
  endtask
  // One instruction: its step list, with memory waits inserted in steps 0/3/5.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input bit rnd, input int wmem, input bit rst_mid);
    int steps[$];
    opcode = op;
    funct = fn;
    zero = z;
    case (op)
      6'b100011: steps = '{0, 1, 2, 3, 4};
      6'b101011: steps = '{0, 1, 2, 5};
      6'b000000: steps = '{0, 1, 6, 7};
      6'b001000: steps = '{0, 1, 9, 10};
      6'b000100: steps = '{0, 1, 8};
      6'b000010: steps = '{0, 1, 11};
      default:   steps = '{0, 1};
    endcase
    foreach (steps[i]) begin
      int s;
      bit waitable;
      int nw;
      s = steps[i];
      waitable = s == 0 || s == 3 || s == 5;
      nw = !waitable ? 0 : rnd ? int'($urandom_range(0, 2)) : (s == 0 ? 0 : wmem);
      for (int k = 0; k <= nw; k++) begin
        bit mr;
        bit r;
        mr = waitable ? (k == nw) : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        if (rnd && s != 8) zero = 1'($urandom_range(0, 1));
        r = rst_mid && s != 0 && waitable && k == 0 && nw > 0;
        drive(s, mr, r);
        if (r) return;
      end
    end
  endtask
  initial begin
    logic [5:0] ops[6];
    logic [5:0] fns[6];
    logic [5:0] op;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011111};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr(6'b100011, 6'd0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(6'b000000, 6'b101010, 1'b0, 1'b0, 0, 1'b0);
    run_instr(6'b000100, 6'd0, 1'b1, 1'b0, 0, 1'b0);
    run_instr(6'b000100, 6'd0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(6'b101011, 6'd0, 1'b0, 1'b0, 3, 1'b0);
    run_instr(6'b111111, 6'd0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(6'b001000, 6'd0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(6'b000010, 6'd0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(6'b100011, 6'd0, 1'b0, 1'b0, 2, 1'b1);
    run_instr(6'b000000, 6'b110011, 1'b0, 1'b0, 0, 1'b0);
    run_instr(6'b101011, 6'd0, 1'b0, 1'b0, 2, 1'b1);
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end else op = ops[$urandom_range(0, 5)];
      run_instr(op, $urandom_range(0, 3) == 0 ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 5)],
                1'($urandom_range(0, 1)), 1'b1, 0, $urandom_range(0, 15) == 0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
